// File: rtl/vpu_req_arbiter.sv
// Round-robin arbiter sharing one VPU request port among REQ_CNT requesters.
// Keeps one operation in flight, returns completion as a done pulse and runs a watchdog on BUSY.
module vpu_req_arbiter #(
  parameter int REQ_CNT        = 4,
  parameter int PAYLOAD_WIDTH  = 64,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = $clog2(TIMEOUT_CYCLES + 1),
  localparam int OW            = $clog2(REQ_CNT)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [REQ_CNT-1:0]                 req_valid_i,
  output logic [REQ_CNT-1:0]                 req_ready_o,
  input  logic [REQ_CNT*PAYLOAD_WIDTH-1:0]   req_payload_i,
  output logic [REQ_CNT-1:0]                 done_o,
  output logic                               vpu_valid_o,
  input  logic                               vpu_ready_i,
  output logic [PAYLOAD_WIDTH-1:0]           vpu_payload_o,
  input  logic                               vpu_done_i,
  output logic                               busy_o,
  output logic [OW-1:0]                      owner_o,
  output logic                               err_o,
  input  logic                               err_clr_i
);

  // state | meaning
  // IDLE  | waiting for any req_valid_i; grants and latches payload on accept
  // ISSUE | vpu_valid_o held high until the VPU takes the request
  // BUSY  | operation in flight; watchdog counting
  // DONE  | done_o pulse to the owner, then back to IDLE
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_DONE} state_t;

  localparam int            CW       = (CNT_WIDTH < 1) ? 1 : CNT_WIDTH;
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [OW-1:0] LAST_REQ = OW'(REQ_CNT - 1);

  state_t                   state;
  logic [OW-1:0]            rr_ptr;
  logic [CW-1:0]            wd_cnt;
  logic                     grant_vld;
  logic [OW-1:0]            grant_idx;
  logic                     timeout_hit;
  logic                     err_set;
  logic [PAYLOAD_WIDTH-1:0] payload_arr [REQ_CNT];

  for (genvar gi = 0; gi < REQ_CNT; gi++) begin : g_payload
    assign payload_arr[gi] = req_payload_i[gi*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
  end

  // Walk offsets from the far end so the nearest valid requester to rr_ptr wins.
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = REQ_CNT - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= REQ_CNT) idx = idx - REQ_CNT;
      if (req_valid_i[OW'(idx)]) begin
        grant_vld = 1'b1;
        grant_idx = OW'(idx);
      end
    end
  end

  // Accept is combinational, but must vanish while reset is asserted.
  always_comb begin
    req_ready_o = '0;
    if (rst_n && state == S_IDLE && grant_vld) req_ready_o[grant_idx] = 1'b1;
  end

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wd_cnt == TO_LAST);
  assign err_set     = (vpu_done_i && state != S_BUSY) ||
                       (state == S_BUSY && !vpu_done_i && timeout_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      rr_ptr        <= '0;
      owner_o       <= '0;
      vpu_payload_o <= '0;
      vpu_valid_o   <= 1'b0;
      done_o        <= '0;
      busy_o        <= 1'b0;
      err_o         <= 1'b0;
      wd_cnt        <= '0;
    end else begin
      done_o <= '0;
      if (err_set)        err_o <= 1'b1;
      else if (err_clr_i) err_o <= 1'b0;

      case (state)
        S_IDLE: begin
          if (grant_vld) begin
            vpu_payload_o <= payload_arr[grant_idx];
            owner_o       <= grant_idx;
            rr_ptr        <= (grant_idx == LAST_REQ) ? '0 : grant_idx + 1'b1;
            vpu_valid_o   <= 1'b1;
            busy_o        <= 1'b1;
            state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (vpu_ready_i) begin
            vpu_valid_o <= 1'b0;
            wd_cnt      <= '0;
            state       <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (wd_cnt != '1) wd_cnt <= wd_cnt + 1'b1;
          if (vpu_done_i || timeout_hit) begin
            done_o[owner_o] <= 1'b1;
            state           <= S_DONE;
          end
        end
        S_DONE: begin
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vpu_req_arbiter.sv
// Scoreboard bench for vpu_req_arbiter: stimulus tasks push expected issues/completions,
// an independent monitor pops and compares whenever the DUT presents them.
module tb_vpu_req_arbiter;
  localparam int N   = 4;
  localparam int PW  = 64;
  localparam int TO  = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid_i;
  logic [N-1:0]    req_ready_o;
  logic [N*PW-1:0] req_payload_i;
  logic [N-1:0]    done_o;
  logic            vpu_valid_o;
  logic            vpu_ready_i;
  logic [PW-1:0]   vpu_payload_o;
  logic            vpu_done_i;
  logic            busy_o;
  logic [1:0]      owner_o;
  logic            err_o;
  logic            err_clr_i;

  vpu_req_arbiter #(.REQ_CNT(N), .PAYLOAD_WIDTH(PW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_payload_i(req_payload_i),
    .done_o(done_o), .vpu_valid_o(vpu_valid_o), .vpu_ready_i(vpu_ready_i),
    .vpu_payload_o(vpu_payload_o), .vpu_done_i(vpu_done_i), .busy_o(busy_o),
    .owner_o(owner_o), .err_o(err_o), .err_clr_i(err_clr_i)
  );

  always #5 clk = ~clk;

  typedef struct { int owner; bit err; } done_t;

  logic [PW-1:0] q_issue [$];
  done_t         q_done  [$];
  logic [PW-1:0] pl [N];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            m_rr    = 0;
  bit            m_err   = 1'b0;
  bit            force_a5 = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: first valid requester at or after the pointer, wrapping.
  function automatic int model_pick(input logic [N-1:0] mask, input int rr);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (rr + k) % N;
      if (mask[i]) return i;
    end
    return -1;
  endfunction

  task automatic new_payloads();
    for (int i = 0; i < N; i++) pl[i] = {$urandom, $urandom};
    req_payload_i = {pl[3], pl[2], pl[1], pl[0]};
  endtask

  // Called at a negedge with the DUT idle. dd<0 means the VPU never answers.
  task automatic run_op(input logic [N-1:0] mask, input bit hold, input int rdly,
                        input int dd, input bit abort);
    int g, k, waitc, exp_k;
    bit got, to_pred;
    logic [N-1:0] onehot;
    done_t e;
    new_payloads();
    if (force_a5) begin
      pl[2] = 64'hA5;
      req_payload_i = {pl[3], pl[2], pl[1], pl[0]};
    end
    req_valid_i = mask;
    #1;
    waitc = 0;
    while (req_ready_o == '0 && waitc < 20) begin
      @(negedge clk); #1; waitc++;
    end
    got = (req_ready_o != '0);
    check("accept_seen", got, 1);
    g = model_pick(mask, m_rr);
    if (!got || g < 0) return;
    onehot = N'(1) << g;
    check("req_ready", req_ready_o, onehot);
    q_issue.push_back(pl[g]);
    to_pred = (dd < 0 || dd >= TO);
    if (!abort) begin
      e.owner = g;
      e.err   = m_err | to_pred;
      m_err   = e.err;
      q_done.push_back(e);
    end
    m_rr = (g + 1) % N;

    @(negedge clk);
    if (!hold) req_valid_i = '0;
    new_payloads();
    vpu_ready_i = (rdly == 0);
    #1 check("valid_latency", vpu_valid_o, 1);
    for (int c = 0; c < rdly; c++) begin
      @(negedge clk);
      vpu_ready_i = (c == rdly - 1);
    end
    @(negedge clk);
    vpu_ready_i = 1'b0;
    vpu_done_i  = (dd == 0);
    k = 0;
    while (k < 64) begin
      @(negedge clk);
      vpu_done_i = 1'b0;
      #1; k++;
      if (abort && k == 3) begin
        rst_n = 1'b0;
        #1;
        check("rst_valid", vpu_valid_o, 0);
        check("rst_ready", req_ready_o, 0);
        check("rst_done", done_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_err", err_o, 0);
        check("rst_owner", owner_o, 0);
        check("rst_payload", vpu_payload_o, 0);
        q_issue.delete();
        q_done.delete();
        m_rr = 0;
        m_err = 1'b0;
        for (int c = 0; c < 2; c++) begin
          @(negedge clk); #1 check("rst_no_done", done_o, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (done_o != '0) break;
      if (k == dd) vpu_done_i = 1'b1;
    end
    exp_k = to_pred ? TO : dd + 1;
    check("done_latency", k, exp_k);
    @(negedge clk);
    #1 check("busy_after", busy_o, 0);
  endtask

  task automatic spurious_seq();
    err_clr_i = 1'b1;
    @(negedge clk); err_clr_i = 1'b0;
    #1 check("err_cleared", err_o, 0);
    vpu_done_i = 1'b1;
    @(negedge clk); vpu_done_i = 1'b0;
    #1 check("spurious_err", err_o, 1);
    check("spurious_idle", busy_o, 0);
    vpu_done_i = 1'b1; err_clr_i = 1'b1;
    @(negedge clk); vpu_done_i = 1'b0; err_clr_i = 1'b0;
    #1 check("set_wins", err_o, 1);
    err_clr_i = 1'b1;
    @(negedge clk); err_clr_i = 1'b0;
    #1 check("err_clr_final", err_o, 0);
    m_err = 1'b0;
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard queues.
  initial begin
    forever begin
      @(negedge clk); #3;
      if (rst_n) begin
        if (vpu_valid_o) begin
          check("ready_during_issue", req_ready_o, 0);
          if (q_issue.size() == 0) check("issue_unexpected", vpu_valid_o, 0);
          else begin
            check("vpu_payload", vpu_payload_o, q_issue[0]);
            if (vpu_ready_i) void'(q_issue.pop_front());
          end
        end
        if (done_o != '0) begin
          if (q_done.size() == 0) check("done_unexpected", done_o, 0);
          else begin
            done_t e;
            logic [N-1:0] oh;
            e  = q_done.pop_front();
            oh = N'(1) << e.owner;
            check("done_onehot", done_o, oh);
            check("done_owner", owner_o, e.owner);
            check("done_err", err_o, e.err);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n = 1'b0; req_valid_i = '0; vpu_ready_i = 1'b0; vpu_done_i = 1'b0; err_clr_i = 1'b0;
    new_payloads();
    #1;
    check("init_valid", vpu_valid_o, 0);
    check("init_busy", busy_o, 0);
    check("init_err", err_o, 0);
    check("init_done", done_o, 0);
    check("init_owner", owner_o, 0);
    check("init_payload", vpu_payload_o, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    force_a5 = 1'b1;
    run_op(4'b0100, 0, 0, 9, 0);
    force_a5 = 1'b0;
    run_op(4'b0110, 0, 0, 2, 0);
    run_op(4'b0110, 0, 0, 2, 0);
    run_op(4'b1011, 0, 5, 1, 0);
    run_op(4'b0001, 0, 0, -1, 0);
    spurious_seq();
    run_op(4'b0010, 0, 1, TO - 1, 0);
    #1 check("no_err_done_wins", err_o, 0);
    run_op(4'b1111, 1, 0, 40, 1);
    for (int i = 0; i < 8; i++) run_op(4'b1111, 1, 0, i % 3, 0);
    for (int i = 0; i < 40; i++) begin
      logic [N-1:0] m;
      int dd;
      m  = N'($urandom_range(1, 15));
      dd = $urandom_range(0, 24);
      if (dd > 20) dd = -1;
      run_op(m, $urandom_range(0, 1) == 1, $urandom_range(0, 3), dd, 0);
    end

    req_valid_i = '0;
    repeat (4) @(negedge clk);
    check("issue_queue_empty", q_issue.size(), 0);
    check("done_queue_empty", q_done.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
